// File: rtl/exe_mem_register.sv
// EX/MEM pipeline register with memory-access FSM, freeze hold and a freeze watchdog.
// Optional EXE_MEM_STALL_COUNTER_EN adds a saturating 32-bit freeze-cycle counter on stallCount.
module exe_mem_register #(
    parameter int DATA_W         = 32,
    parameter int DEST_W         = 4,
    parameter int FREEZE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exValid,
    input  logic              exWbEnable,
    input  logic              exMemReadEnabled,
    input  logic              exMemWriteEnabled,
    input  logic [DEST_W-1:0] exDest,
    input  logic [DATA_W-1:0] exAluResult,
    input  logic [DATA_W-1:0] exValRm,
    input  logic              freeze,
    output logic              valid,
    output logic              wbEnable,
    output logic              memoryReadEnabled,
    output logic              memoryWriteEnabled,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] valRm,
    output logic              memBusy,
    output logic              accessDone,
    output logic              timeoutError,
    output logic [31:0]       stallCount
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(FREEZE_TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic [7:0] freeze_cnt;
    logic [7:0] freeze_cnt_next;
    logic       load_mem_op;

    assign load_mem_op = exValid & (exMemReadEnabled | exMemWriteEnabled);

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid              <= 1'b0;
            wbEnable           <= 1'b0;
            memoryReadEnabled  <= 1'b0;
            memoryWriteEnabled <= 1'b0;
            dest               <= '0;
            aluResult          <= '0;
            valRm              <= '0;
        end else if (!freeze) begin
            // A bubble clears everything; a read beats a simultaneous write.
            valid              <= exValid;
            wbEnable           <= exValid & exWbEnable;
            memoryReadEnabled  <= exValid & exMemReadEnabled;
            memoryWriteEnabled <= exValid & exMemWriteEnabled & ~exMemReadEnabled;
            dest               <= exValid ? exDest      : '0;
            aluResult          <= exValid ? exAluResult : '0;
            valRm              <= exValid ? exValRm     : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred on any path.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!freeze && load_mem_op) state_next = ACCESS;
            ACCESS:  if (!freeze) state_next = load_mem_op ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign memBusy    = (state == ACCESS);
    assign accessDone = (state == ACCESS) && !freeze;

    always_comb begin
        freeze_cnt_next = 8'd0;
        if (freeze) begin
            freeze_cnt_next = (freeze_cnt == TIMEOUT) ? freeze_cnt : freeze_cnt + 8'd1;
        end
    end

    // The error flag rises on the same edge the counter reaches the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freeze_cnt   <= 8'd0;
            timeoutError <= 1'b0;
        end else begin
            freeze_cnt   <= freeze_cnt_next;
            timeoutError <= timeoutError | (freeze_cnt_next == TIMEOUT);
        end
    end

`ifdef EXE_MEM_STALL_COUNTER_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
        end else if (freeze && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stallCount = stall_cnt;
`else
    assign stallCount = 32'd0;
`endif

endmodule

// File: tb/tb_exe_mem_register.sv
// Randomised and directed bench for exe_mem_register against a behavioural model
// of the held instruction, freeze streak and stall total.
module tb_exe_mem_register;

    localparam int DATA_W = 32;
    localparam int DEST_W = 4;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              exValid, exWbEnable, exMemReadEnabled, exMemWriteEnabled;
    logic [DEST_W-1:0] exDest;
    logic [DATA_W-1:0] exAluResult, exValRm;
    logic              freeze;
    logic              valid, wbEnable, memoryReadEnabled, memoryWriteEnabled;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] aluResult, valRm;
    logic              memBusy, accessDone, timeoutError;
    logic [31:0]       stallCount;

    exe_mem_register #(
        .DATA_W(DATA_W), .DEST_W(DEST_W), .FREEZE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .exValid(exValid), .exWbEnable(exWbEnable),
        .exMemReadEnabled(exMemReadEnabled), .exMemWriteEnabled(exMemWriteEnabled),
        .exDest(exDest), .exAluResult(exAluResult), .exValRm(exValRm),
        .freeze(freeze),
        .valid(valid), .wbEnable(wbEnable),
        .memoryReadEnabled(memoryReadEnabled), .memoryWriteEnabled(memoryWriteEnabled),
        .dest(dest), .aluResult(aluResult), .valRm(valRm),
        .memBusy(memBusy), .accessDone(accessDone),
        .timeoutError(timeoutError), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    // Reference model: the instruction currently held, plus freeze history.
    typedef struct {
        bit          valid, wb, rd, wr;
        logic [3:0]  dest;
        logic [31:0] alu, rm;
    } instr_t;

    instr_t      held;
    int          streak;
    bit          m_timeout;
    longint      m_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        held      = '{default: 0};
        streak    = 0;
        m_timeout = 0;
        m_stall   = 0;
    endtask

    // Applies one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        if (!freeze) begin
            if (exValid) begin
                held.valid = 1;
                held.wb    = exWbEnable;
                held.rd    = exMemReadEnabled;
                held.wr    = exMemWriteEnabled && !exMemReadEnabled;
                held.dest  = exDest;
                held.alu   = exAluResult;
                held.rm    = exValRm;
            end else begin
                held = '{default: 0};
            end
            streak = 0;
        end else begin
            streak++;
            if (m_stall < 64'hFFFF_FFFF) m_stall++;
        end
        if (streak >= TO) m_timeout = 1;
    endtask

    task automatic check_all();
        bit busy;
        busy = held.rd || held.wr;
        check("valid", valid, held.valid);
        check("wb", wbEnable, held.wb);
        check("rd", memoryReadEnabled, held.rd);
        check("wr", memoryWriteEnabled, held.wr);
        check("dest", dest, held.dest);
        check("alu", aluResult, held.alu);
        check("rm", valRm, held.rm);
        check("busy", memBusy, busy);
        check("done", accessDone, busy && !freeze);
        check("timeout", timeoutError, m_timeout);
`ifdef EXE_MEM_STALL_COUNTER_EN
        check("stall", stallCount, m_stall);
`else
        check("stall", stallCount, 0);
`endif
        if (accessDone === 1'b1) done_seen++;
    endtask

    // Called at a falling edge: drive, check, clock, return at next falling edge.
    task automatic step(input bit v, input bit wb, input bit rd, input bit wr,
                        input logic [3:0] d, input logic [31:0] a, input logic [31:0] r,
                        input bit f);
        exValid = v; exWbEnable = wb; exMemReadEnabled = rd; exMemWriteEnabled = wr;
        exDest = d; exAluResult = a; exValRm = r; freeze = f;
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_all_inputs(input bit val);
        exValid = val; exWbEnable = val; exMemReadEnabled = val; exMemWriteEnabled = val;
        exDest = val ? '1 : '0; exAluResult = val ? '1 : '0; exValRm = val ? '1 : '0;
        freeze = val;
    endtask

    // Asynchronous reset mid-cycle with all inputs high; outputs must clear at once.
    task automatic async_reset();
        set_all_inputs(1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_rd", memoryReadEnabled, 0);
        check("rst_wr", memoryWriteEnabled, 0);
        check("rst_alu", aluResult, 0);
        check("rst_busy", memBusy, 0);
        check("rst_done", accessDone, 0);
        check("rst_timeout", timeoutError, 0);
        check("rst_stall", stallCount, 0);
        model_reset();
        @(negedge clk);
        set_all_inputs(1'b0);
        #1 rst = 1'b1;
        @(negedge clk);
        model_edge();
    endtask

    initial begin
        rst = 1'b0;
        set_all_inputs(1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_edge();

        // Load something, then reset in the middle of a frozen access.
        step(1, 1, 1, 0, 4'd3, 32'h100, 32'h0, 0);
        step(1, 1, 0, 0, 4'd1, 32'h0, 32'h0, 1);
        async_reset();
        #1 check("post_rst_valid", valid, 0);
        check("post_rst_busy", memBusy, 0);

        // ALU instruction, no memory access.
        done_seen = 0;
        step(1, 1, 0, 0, 4'd5, 32'h10, 32'h0, 0);
        #1 check("alu_dest", dest, 5);
        check("alu_res", aluResult, 32'h10);
        check("alu_wb", wbEnable, 1);
        step(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0);
        check("alu_no_done", done_seen, 0);

        // Load frozen for 4 cycles while EX moves on.
        step(1, 1, 1, 0, 4'd2, 32'h400, 32'h0, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 4'd6, 32'h800, 32'h0, 1);
            #1 check("ld_hold", aluResult, 32'h400);
            check("ld_busy", memBusy, 1);
        end
`ifdef EXE_MEM_STALL_COUNTER_EN
        check("ld_stall", stallCount, 4);
`endif
        step(1, 1, 0, 0, 4'd6, 32'h800, 32'h0, 0);
        check("ld_done_once", done_seen, 1);
        #1 check("ld_next", aluResult, 32'h800);

        // Store then load back to back, each frozen 2 cycles.
        done_seen = 0;
        step(1, 0, 0, 1, 4'd0, 32'h20, 32'hBEEF, 0);
        repeat (2) step(1, 1, 1, 0, 4'd7, 32'h30, 32'h0, 1);
        #1 check("b2b_wr", memoryWriteEnabled, 1);
        step(1, 1, 1, 0, 4'd7, 32'h30, 32'h0, 0);
        #1 check("b2b_rd", memoryReadEnabled, 1);
        check("b2b_busy", memBusy, 1);
        repeat (2) step(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0);
        check("b2b_two_done", done_seen, 2);

        // Read/write conflict.
        step(1, 0, 1, 1, 4'd9, 32'h44, 32'h55, 0);
        #1 check("conf_rd", memoryReadEnabled, 1);
        check("conf_wr", memoryWriteEnabled, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, 4'($urandom), $urandom, $urandom,
                 $urandom_range(0, 9) < 3);
        end

        // Watchdog from a clean reset.
        async_reset();
        for (int i = 1; i <= TO; i++) begin
            step(1, 1, 0, 0, 4'd1, 32'h1, 32'h0, 1);
            #1 check("wd_flag", timeoutError, i == TO);
        end
        repeat (3) step(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0);
        #1 check("wd_sticky", timeoutError, 1);
        async_reset();
        #1 check("wd_cleared", timeoutError, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_mem_register.md
Name: exe_mem_register

Overview:
- EX/MEM pipeline register of the ARM core. It captures execute-stage results and presents them to the memory stage as `aluResult`, `valRm` and the read/write enables.
- It holds its contents while the memory stage's `SRAMFreeze` is high, and tracks each memory access with a small FSM.
- It drives hazard/forwarding status (`dest`, `wbEnable`, `memBusy`) and a stall watchdog.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- DEST_W, 4, register-file index width.
- FREEZE_TIMEOUT, 64, consecutive freeze cycles after which `timeoutError` is raised; legal range 2..255.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- exValid  in  1  EX stage holds a real instruction (0 = bubble).
- exWbEnable  in  1  instruction writes the register file.
- exMemReadEnabled  in  1  load.
- exMemWriteEnabled  in  1  store.
- exDest  in  DEST_W  destination register.
- exAluResult  in  DATA_W  address or ALU value.
- exValRm  in  DATA_W  store data.
- freeze  in  1  `SRAMFreeze` from the memory stage.
- valid  out  1  registered instruction is real.
- wbEnable  out  1  registered write-back enable.
- memoryReadEnabled  out  1  to memory stage.
- memoryWriteEnabled  out  1  to memory stage.
- dest  out  DEST_W  registered destination.
- aluResult  out  DATA_W  to memory stage address.
- valRm  out  DATA_W  to memory stage data.
- memBusy  out  1  FSM in ACCESS.
- accessDone  out  1  memory access completes this cycle.
- timeoutError  out  1  sticky watchdog flag.
- stallCount  out  32  optional freeze-cycle counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs and registers go to 0.
  - FSM goes to IDLE.
  - Freeze counter goes to 0.
  - Reset mid-access abandons the access immediately; no `accessDone` is produced.
- Load, when freeze=0 at a clock edge:
  - Capture all `ex*` inputs.
  - If exValid=0, load a bubble: valid, wbEnable, both memory enables = 0; dest/aluResult/valRm = 0.
- Hold, when freeze=1: every registered output keeps its value, regardless of EX inputs.
- Read/write conflict: if exMemReadEnabled and exMemWriteEnabled are both 1, the read wins and the registered write enable is forced to 0.
- Latency: one cycle from EX input to output when not frozen.
- FSM states:
  - IDLE: no memory operation held.
  - ACCESS: a load or store is held.
- FSM transitions:
  - IDLE -> ACCESS on a load edge capturing an enabled read or write.
  - ACCESS with freeze=0: `accessDone`=1 (combinational, state==ACCESS and freeze==0).
    - Next state is ACCESS if the newly loaded instruction is a memory op, else IDLE.
    - Back-to-back memory ops get one `accessDone` per op.
  - ACCESS with freeze=1: remain in ACCESS.
- `memBusy` = (state==ACCESS).
- Freeze while IDLE (spurious): the register holds anyway, no state change, and the cycle counts toward the watchdog.
- Watchdog:
  - 8-bit counter, incremented each cycle freeze=1, cleared on any cycle freeze=0.
  - When the counter reaches FREEZE_TIMEOUT, `timeoutError` is set.
  - `timeoutError` stays set until reset; the counter saturates at FREEZE_TIMEOUT.
- Forwarding: dest/wbEnable/valid are always the registered values, including while frozen.

Optional Feature:
- Macro: EXE_MEM_STALL_COUNTER_EN.
- Defined: `stallCount` is a 32-bit counter.
  - Reset to 0; increments on every clock with freeze=1.
  - Saturates at 0xFFFFFFFF and is never cleared except by reset.
- Undefined: `stallCount` is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset: drive rst=0 mid-operation with all inputs =1 -> every output 0 immediately (before the next edge); after rst=1, valid=0, memBusy=0.
- ALU instruction, freeze=0: exValid=1, exWbEnable=1, exDest=5, exAluResult=0x0000_0010 -> one edge later dest=5, aluResult=0x10, wbEnable=1, memBusy=0, accessDone never 1.
- Load with 4-cycle freeze:
  - Stimulus: exMemReadEnabled=1, exAluResult=0x400.
  - Freeze 1 for 4 cycles, then 0, while EX changes to exAluResult=0x800.
  - Required: aluResult stays 0x400 and memBusy=1 throughout the freeze; accessDone=1 in exactly the first freeze=0 cycle; next edge loads 0x800; stallCount=4 with EXE_MEM_STALL_COUNTER_EN.
- Back-to-back store then load, each frozen 2 cycles -> two separate accessDone pulses; memBusy continuously 1; memoryWriteEnabled then memoryReadEnabled in sequence.
- Conflict: exMemReadEnabled=1 and exMemWriteEnabled=1 -> memoryReadEnabled=1, memoryWriteEnabled=0.
- Watchdog, FREEZE_TIMEOUT=8: hold freeze=1 for 8 cycles -> timeoutError rises after the 8th frozen edge and stays 1 after freeze drops, until rst=0.
